// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, controller state encoding
// and the round-constant lookup.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/g_function.sv
// AES key-schedule g-function: RotWord, SubWord, then XOR of rcon into the top byte.
module g_function (
  input  logic [31:0] word_i,
  input  logic [7:0]  rcon_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] rot;

  assign rot    = {word_i[23:0], word_i[31:24]};
  assign word_o = {SBOX[rot[31:24]] ^ rcon_i, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};

endmodule

// File: rtl/inv_key_generator.sv
// AES-128 decryption round-key generator: pre-expands K0 to K10, then walks the
// schedule backwards one round key per accepted request.
module inv_key_generator
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BLOCK_LENGTH-1:0] key,
  input  logic                    en,
  input  logic [3:0]              Round_Count,
  output logic [BLOCK_LENGTH-1:0] current_key,
  output logic                    key_valid,
  output logic                    ready
);

  localparam logic [3:0] CNT_DONE  = 4'(NUM_ROUNDS + 1);
  localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [BLOCK_LENGTH-1:0] work_q, work_d;
  logic [BLOCK_LENGTH-1:0] k10_q, k10_d;
  logic [BLOCK_LENGTH-1:0] cur_key_q, cur_key_d;
  logic                    key_valid_q, key_valid_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] g_in, g_out;
  logic [7:0]  g_rcon;
  logic [31:0] f4, f5, f6, f7;
  logic [31:0] v0, v1, v2, v3;
  logic [BLOCK_LENGTH-1:0] fwd_key, inv_key;

  assign w0 = work_q[127:96];
  assign w1 = work_q[95:64];
  assign w2 = work_q[63:32];
  assign w3 = work_q[31:0];

  // One g instance serves both directions; only its operand and rcon index change.
  assign g_in   = (state_q == EXPAND) ? w3 : (w3 ^ w2);
  assign g_rcon = (state_q == EXPAND) ? rcon(cnt_q) : rcon(4'd11 - Round_Count);

  g_function u_g (
    .word_i (g_in),
    .rcon_i (g_rcon),
    .word_o (g_out)
  );

  assign f4      = w0 ^ g_out;
  assign f5      = w1 ^ f4;
  assign f6      = w2 ^ f5;
  assign f7      = w3 ^ f6;
  assign fwd_key = {f4, f5, f6, f7};

  assign v3      = w3 ^ w2;
  assign v2      = w2 ^ w1;
  assign v1      = w1 ^ w0;
  assign v0      = w0 ^ g_out;
  assign inv_key = {v0, v1, v2, v3};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    k10_d       = k10_q;
    cur_key_d   = cur_key_q;
    key_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        // The final step has already landed in work; park it as K10.
        if (cnt_q == CNT_DONE) begin
          k10_d   = work_q;
          state_d = READY;
        end else begin
          work_d = fwd_key;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      READY: begin
        if (start) begin
          work_d  = key;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end else if (en) begin
          if (Round_Count == 4'd0) begin
            work_d      = k10_q;
            cur_key_d   = k10_q;
            key_valid_d = 1'b1;
          end else if (Round_Count <= MAX_ROUND) begin
            work_d      = inv_key;
            cur_key_d   = inv_key;
            key_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      work_q      <= '0;
      k10_q       <= '0;
      cur_key_q   <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      k10_q       <= k10_d;
      cur_key_q   <= cur_key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign current_key = cur_key_q;
  assign key_valid   = key_valid_q;
  assign ready       = (state_q == READY);

endmodule

// File: tb/tb_inv_key_generator.sv
// Self-checking bench for inv_key_generator against an AES key-expansion model
// that derives the S-box from GF(2^8) inversion.
module tb_inv_key_generator;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         en;
  logic [3:0]   Round_Count;
  logic [127:0] current_key;
  logic         key_valid;
  logic         ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] rk     [0:10];
  logic [127:0] exp_key;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_key_generator #(.BLOCK_LENGTH(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .en          (en),
    .Round_Count (Round_Count),
    .current_key (current_key),
    .key_valid   (key_valid),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_chk++;
    if (got !== expv)
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic run_expand(input logic [127:0] k, input bit poke_en, input bit poke_start,
                            input bit en_with_start);
    key   = k;
    start = 1'b1;
    if (en_with_start) begin en = 1'b1; Round_Count = 4'd1; end
    tick();
    start = 1'b0;
    en    = 1'b0;
    key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    chk("ready_at_start", 128'(ready), 128'(0));
    chk("kv_at_start", 128'(key_valid), 128'(0));
    chk("key_held_at_start", current_key, exp_key);
    for (int i = 1; i <= 11; i++) begin
      if (poke_en && i == 3) begin en = 1'b1; Round_Count = 4'd0; end
      if (poke_start && i == 5) begin start = 1'b1; key = ~k; end
      tick();
      en    = 1'b0;
      start = 1'b0;
      chk($sformatf("ready_cycle%0d", i), 128'(ready), 128'(i == 11));
      if (poke_en && i == 3) begin
        chk("kv_en_in_expand", 128'(key_valid), 128'(0));
        chk("key_held_en_in_expand", current_key, exp_key);
      end
    end
    model_expand(k);
  endtask

  task automatic deliver(input int n);
    en          = 1'b1;
    Round_Count = 4'(n);
    tick();
    en = 1'b0;
    if (n == 0) exp_key = rk[10];
    else if (n <= 10) exp_key = rk[10 - n];
    chk($sformatf("kv_rc%0d", n), 128'(key_valid), 128'(n <= 10));
    chk($sformatf("round_key_rc%0d", n), current_key, exp_key);
  endtask

  task automatic idle_cycle();
    tick();
    chk("kv_idle", 128'(key_valid), 128'(0));
    chk("key_held_idle", current_key, exp_key);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; en = 1'b0; key = '0; Round_Count = 4'd0;
    exp_key = '0;
    build_sbox();

    tick();
    tick();
    chk("reset_ready", 128'(ready), 128'(0));
    chk("reset_kv", 128'(key_valid), 128'(0));
    chk("reset_key", current_key, 128'(0));
    rst = 1'b1;
    tick();

    // Known-answer walk with en poked during expansion.
    run_expand(KEY_A, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n <= 10; n++) begin
      deliver(n);
      case (n)
        0:  chk("spec_k10", current_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        1:  chk("spec_k9",  current_key, 128'hac7766f319fadc2128d12941575c006e);
        9:  chk("spec_k1",  current_key, 128'ha0fafe1788542cb123a339392a6c7605);
        10: chk("spec_k0",  current_key, KEY_A);
        default: ;
      endcase
    end
    idle_cycle();

    // Out-of-range round is dropped, then K10 is delivered again.
    deliver(12);
    deliver(0);
    chk("spec_k10_again", current_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start beats en in READY; start during EXPAND must not restart.
    run_expand({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n <= 10; n++) deliver(n);

    // Reset in the middle of an expansion.
    key = KEY_A; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_key = '0;
    chk("midrst_ready", 128'(ready), 128'(0));
    chk("midrst_kv", 128'(key_valid), 128'(0));
    chk("midrst_key", current_key, 128'(0));
    en = 1'b1; Round_Count = 4'd0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("midrst_en_ignored_kv", 128'(key_valid), 128'(0));
      chk("midrst_en_ignored_ready", 128'(ready), 128'(0));
    end
    en = 1'b0;
    chk("midrst_key_still_zero", current_key, 128'(0));
    run_expand(KEY_A, 1'b0, 1'b0, 1'b0);
    deliver(0);

    // Randomized keys with idle gaps and out-of-range requests between rounds.
    for (int it = 0; it < 6; it++) begin
      run_expand({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n <= 10; n++) begin
        case ($urandom_range(0, 3))
          1: idle_cycle();
          2: deliver(int'($urandom_range(11, 15)));
          default: ;
        endcase
        deliver(n);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inv_key_generator.md
INV_KEY_GENERATOR -- requirements
Module: inv_key_generator

Interface
REQ-001 The block SHALL have parameter BLOCK_LENGTH, default 128, giving the key and round-key width (only 128 supported).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle request to latch key and pre-expand the schedule to K10.
REQ-005 The block SHALL have port key, input, BLOCK_LENGTH bits: cipher key K0, sampled only on an accepted start.
REQ-006 The block SHALL have port en, input, 1 bit: request for the next decryption round key, from the decrypt FSM.
REQ-007 The block SHALL have port Round_Count, input, 4 bits: decryption round 0..10; round n uses key K(10-n).
REQ-008 The block SHALL have port current_key, output reg, BLOCK_LENGTH bits: the delivered round key.
REQ-009 The block SHALL have port key_valid, output reg, 1 bit: one-cycle pulse when current_key is updated.
REQ-010 The block SHALL have port ready, output, 1 bit: high when K10 is available and en is accepted.

Function
REQ-011 The block SHALL have states IDLE, EXPAND and READY, with ready = (state == READY).
REQ-012 In IDLE or READY, start SHALL load work <= key, set cnt <= 1 and go to EXPAND.
REQ-013 In EXPAND, each cycle SHALL compute work <= fwd(work, rcon(cnt)) and cnt <= cnt+1.
REQ-014 fwd SHALL be: w4=w0^g(w3), w5=w1^w4, w6=w2^w5, w7=w3^w6.
REQ-015 When the cnt==10 step is done, the block SHALL load k10_reg <= the result and go to READY, so ready rises exactly 11 cycles after the start edge.
REQ-016 start during EXPAND SHALL be ignored, and the expansion SHALL not restart.
REQ-017 en outside READY SHALL be ignored: key_valid = 0 and current_key holds.
REQ-018 In READY, en with Round_Count==0 SHALL set current_key <= k10_reg and work <= k10_reg.
REQ-019 In READY, en with Round_Count==n, 1<=n<=10, SHALL set current_key and work to inv(work, rcon(11-n)).
REQ-020 inv SHALL be: v3=w3^w2, v2=w2^w1, v1=w1^w0, v0=w0^g(v3).
REQ-021 Non-sequential Round_Count values SHALL be applied to the current work without any error flag; the key is valid only for the sequence 0,1,..,10.
REQ-022 In READY, en with Round_Count>10 SHALL leave current_key and work unchanged and set key_valid = 0.
REQ-023 key_valid SHALL be 1 in the cycle after each accepted en (latency 1) and 0 otherwise; back-to-back en SHALL give back-to-back pulses.
REQ-024 If start and en occur together in READY, start SHALL win and en SHALL be dropped (key_valid = 0).
REQ-025 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), with 00 otherwise.
REQ-026 A single g-function instance SHALL be shared, with its input muxed between w3 (EXPAND) and w3^w2 (READY).

Reset
REQ-027 When rst = 0 at a clock edge, state SHALL become IDLE, and cnt, work, k10_reg and current_key SHALL become 0.
REQ-028 On that same reset, key_valid SHALL become 0 and ready SHALL become 0.
REQ-029 Reset mid-EXPAND or mid-READY SHALL abort; a new start is required afterwards.

Structure
REQ-030 The block SHALL use a shared package aes_pkg holding the rcon lookup function.
REQ-031 aes_pkg SHALL also hold NUM_ROUNDS = 10 and the state encoding.
REQ-032 The block SHALL instantiate the existing g_function sub-module (SubWord/RotWord/Rcon XOR) once, and no other sub-module.
REQ-033 Total storage SHALL be about 3x128 + 6 flops: work, k10_reg, current_key, cnt and state.

Verification
REQ-034 Bench SHALL drive start with key=2b7e151628aed2a6abf7158809cf4f3c and check: ready rises 11 cycles later, and en with Round_Count=0 gives current_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and key_valid=1 one cycle later.
REQ-035 Bench SHALL then drive en with Round_Count 1..10 back-to-back and check: n=1 gives ac7766f319fadc2128d12941575c006e, n=9 gives a0fafe1788542cb123a339392a6c7605, n=10 gives 2b7e1516...cf4f3c, with key_valid high for 11 consecutive cycles.
REQ-036 Bench SHALL drive en during EXPAND and check key_valid=0 and current_key unchanged; it SHALL drive start during EXPAND and check ready timing is unchanged.
REQ-037 Bench SHALL drive start and en together in READY and check key_valid=0, ready=0 next cycle and ready back 11 cycles later.
REQ-038 Bench SHALL drive rst=0 for one cycle mid-EXPAND and check all outputs are 0, state is IDLE and en is ignored until a new start.
REQ-039 Bench SHALL drive en with Round_Count=12 in READY and check key_valid=0 and current_key held, then drive Round_Count=0 and check K10 is delivered again.
